// File: rtl/fft8_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fft8_frame_ctrl
// Function : Gathers 8 serial samples into a frame for the FFT core, waits the
//            core latency, then streams the captured bins out one per handshake.
// Revision : 1.0
// ============================================================================
module fft8_frame_ctrl #(
    parameter int CORE_LAT = 1,
    parameter int OUT_BINS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] core_inp,
    output logic         core_start,
    input  logic [255:0] core_out,
    output logic [15:0]  out_real,
    output logic [15:0]  out_imag,
    output logic [2:0]   out_idx,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [15:0]  frame_cnt
);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] LAT_C  = 4'(CORE_LAT);
    localparam logic [2:0] LAST_C = 3'(OUT_BINS - 1);

    state_t      state_q, state_d;
    logic [2:0]  wr_idx_q, wr_idx_d;
    logic [2:0]  rd_idx_q, rd_idx_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] samp_q [8];
    logic [15:0] samp_d [8];
    // Each result word holds {imag, real} for one bin.
    logic [31:0] res_q [8];
    logic [31:0] res_d [8];
    logic        in_fire;
    logic        out_fire;

    always_comb begin
        in_ready   = rst && (state_q == ST_FILL);
        core_start = rst && (state_q == ST_RUN) && (lat_cnt_q == 4'd0);
        out_valid  = rst && (state_q == ST_DRAIN);
        out_last   = out_valid && (rd_idx_q == LAST_C);
        out_real   = res_q[rd_idx_q][15:0];
        out_imag   = res_q[rd_idx_q][31:16];
        out_idx    = rd_idx_q;
        busy       = !((state_q == ST_FILL) && (wr_idx_q == 3'd0));
        frame_cnt  = frame_cnt_q;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        core_inp   = '0;
        for (int k = 0; k < 8; k++) begin
            core_inp[16*k +: 16] = samp_q[k];
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        lat_cnt_d   = lat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        samp_d      = samp_q;
        res_d       = res_q;
        case (state_q)
            ST_FILL: begin
                if (in_fire) begin
                    samp_d[wr_idx_q] = in_data;
                    wr_idx_d         = wr_idx_q + 3'd1;
                    if (wr_idx_q == 3'd7) begin
                        state_d   = ST_RUN;
                        wr_idx_d  = 3'd0;
                        lat_cnt_d = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                lat_cnt_d = lat_cnt_q + 4'd1;
                if (lat_cnt_q == LAT_C) begin
                    // Only the bins that will be emitted are captured; the rest stay cleared.
                    for (int k = 0; k < OUT_BINS; k++) begin
                        res_d[k] = core_out[32*k +: 32];
                    end
                    state_d   = ST_DRAIN;
                    rd_idx_d  = 3'd0;
                    lat_cnt_d = 4'd0;
                end
            end
            ST_DRAIN: begin
                if (out_fire) begin
                    rd_idx_d = rd_idx_q + 3'd1;
                    if (rd_idx_q == LAST_C) begin
                        state_d     = ST_FILL;
                        rd_idx_d    = 3'd0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            wr_idx_q    <= 3'd0;
            rd_idx_q    <= 3'd0;
            lat_cnt_q   <= 4'd0;
            frame_cnt_q <= 16'd0;
            samp_q      <= '{default: 16'h0000};
            res_q       <= '{default: 32'h0000_0000};
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            samp_q      <= samp_d;
            res_q       <= res_d;
        end
    end

endmodule
`default_nettype wire
